// File: rtl/tile_collision_detector.sv
// Scans the level tiles bordering a sprite's bounding box and reports which directions are blocked.
// Optional build macro PLATFORM_TILE_EN: tile code 4'hF becomes a one-way platform (solid only from above).
module tile_collision_detector #(
    parameter int TILE_SHIFT   = 3,
    parameter int LEVEL_COLS   = 2048,
    parameter int LEVEL_ROWS   = 15,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic [31:0] x_location,
    input  logic [6:0]  y_location,
    input  logic [4:0]  width,
    input  logic [4:0]  height,
    output logic [14:0] level_address,
    input  logic [3:0]  tile_code,
    output logic        left,
    output logic        right,
    output logic        up,
    output logic        down,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic        forced;
        logic [14:0] addr;
    } probe_t;

    // Probes 0-1 left, 2-3 right, 4-5 up, 6-7 down; the direction is the index's upper two bits.
    function automatic probe_t probe_at(input logic [31:0] x, input logic [6:0] y,
                                        input logic [4:0] w, input logic [4:0] h,
                                        input logic [2:0] k);
        logic [32:0] xr;
        logic [32:0] xm1;
        logic [8:0]  yb;
        logic [8:0]  ym1;
        logic [32:0] px;
        logic [8:0]  py;
        logic [32:0] col;
        logic [8:0]  row;
        logic        edge_oor;
        probe_t      p;
        xr  = {1'b0, x} + 33'(w);
        xm1 = {1'b0, x} - 33'd1;
        yb  = {2'b00, y} + 9'(h);
        ym1 = {2'b00, y} - 9'd1;
        px = {1'b0, x};
        py = {2'b00, y};
        edge_oor = 1'b0;
        case (k)
            3'd0: begin px = xm1; edge_oor = (x == 32'd0); end
            3'd1: begin px = xm1; py = yb - 9'd1; edge_oor = (x == 32'd0); end
            3'd2: px = xr;
            3'd3: begin px = xr; py = yb - 9'd1; end
            3'd4: begin py = ym1; edge_oor = (y == 7'd0); end
            3'd5: begin px = xr - 33'd1; py = ym1; edge_oor = (y == 7'd0); end
            3'd6: py = yb;
            default: begin px = xr - 33'd1; py = yb; end
        endcase
        col = px >> TILE_SHIFT;
        row = py >> TILE_SHIFT;
        // Column is range-checked at full width so far-right positions never alias onto column 0.
        p.forced = edge_oor || (col >= 33'(LEVEL_COLS)) || (row >= 9'(LEVEL_ROWS));
        p.addr   = p.forced ? 15'd0 : 15'(32'(row) * 32'(LEVEL_COLS) + 32'(col));
        return p;
    endfunction

    state_t      state;
    logic [2:0]  k;
    logic [1:0]  drain_cnt;
    logic [31:0] cap_x;
    logic [6:0]  cap_y;
    logic [4:0]  cap_w;
    logic [4:0]  cap_h;
    logic [3:0]  shadow;

    logic [READ_LATENCY:0] pipe_valid;
    logic [READ_LATENCY:0] pipe_forced;
    logic [1:0]            pipe_dir [0:READ_LATENCY];

    probe_t     first_probe;
    probe_t     next_probe;
    logic [2:0] k_next;
    logic       tile_solid;

    assign k_next      = k + 3'd1;
    assign first_probe = probe_at(x_location, y_location, width, height, 3'd0);
    assign next_probe  = probe_at(cap_x, cap_y, cap_w, cap_h, k_next);

    always_comb begin
        tile_solid = (tile_code != 4'd0);
`ifdef PLATFORM_TILE_EN
        if (tile_code == 4'hF && pipe_dir[READ_LATENCY] != 2'd3)
            tile_solid = 1'b0;
`else
`endif
    end

    // The pipe tracks each issued probe so its data is taken exactly READ_LATENCY cycles after the address.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= IDLE;
            k             <= 3'd0;
            drain_cnt     <= 2'd0;
            level_address <= 15'd0;
            cap_x         <= 32'd0;
            cap_y         <= 7'd0;
            cap_w         <= 5'd0;
            cap_h         <= 5'd0;
            shadow        <= 4'd0;
            left          <= 1'b0;
            right         <= 1'b0;
            up            <= 1'b0;
            down          <= 1'b0;
            done          <= 1'b0;
            pipe_valid    <= '0;
            pipe_forced   <= '0;
            for (int i = 0; i <= READ_LATENCY; i++)
                pipe_dir[i] <= 2'd0;
        end else begin
            for (int i = READ_LATENCY; i > 0; i--) begin
                pipe_valid[i]  <= pipe_valid[i-1];
                pipe_forced[i] <= pipe_forced[i-1];
                pipe_dir[i]    <= pipe_dir[i-1];
            end
            pipe_valid[0] <= 1'b0;

            if (pipe_valid[READ_LATENCY] && (pipe_forced[READ_LATENCY] || tile_solid))
                shadow[pipe_dir[READ_LATENCY]] <= 1'b1;

            case (state)
                IDLE: begin
                    done          <= 1'b0;
                    level_address <= 15'd0;
                    if (enable) begin
                        cap_x          <= x_location;
                        cap_y          <= y_location;
                        cap_w          <= width;
                        cap_h          <= height;
                        shadow         <= 4'd0;
                        k              <= 3'd0;
                        level_address  <= first_probe.addr;
                        pipe_valid[0]  <= 1'b1;
                        pipe_forced[0] <= first_probe.forced;
                        pipe_dir[0]    <= 2'd0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!enable) begin
                        state         <= IDLE;
                        level_address <= 15'd0;
                        pipe_valid    <= '0;
                    end else if (k == 3'd7) begin
                        state         <= DRAIN;
                        level_address <= 15'd0;
                        drain_cnt     <= 2'd0;
                    end else begin
                        level_address  <= next_probe.addr;
                        pipe_valid[0]  <= 1'b1;
                        pipe_forced[0] <= next_probe.forced;
                        pipe_dir[0]    <= k_next[2:1];
                        k              <= k_next;
                    end
                end
                DRAIN: begin
                    if (!enable) begin
                        state      <= IDLE;
                        pipe_valid <= '0;
                    end else if (drain_cnt == 2'(READ_LATENCY)) begin
                        state <= DONE;
                        left  <= shadow[0];
                        right <= shadow[1];
                        up    <= shadow[2];
                        down  <= shadow[3];
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: begin
                    if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/tile_collision_detector.md
# tile_collision_detector

Responder on the main state machine's `enable`/`done` handshake for the DETECT_COLLISIONS state. It reads the level tile memory around the character's bounding box and reports which of the four directions are blocked by solid tiles. The block shares the level memory read port with the background drawer; the main state machine muxes `level_address` by state.

## Interface
Parameters:
- `TILE_SHIFT`, default 3: tile edge is 2^TILE_SHIFT pixels (8).
- `LEVEL_COLS`, default 2048: tiles per level row; address = row*LEVEL_COLS + col.
- `LEVEL_ROWS`, default 15: tile rows (120/8).
- `READ_LATENCY`, default 1: cycles from `level_address` to valid `tile_code`; legal values 1–2.

Ports:
- `clock` in 1: system clock (CLOCK_50 domain).
- `resetn` in 1: synchronous, active-low reset.
- `enable` in 1: request; held high by master until it sees `done`.
- `x_location` in 32: character left edge, world pixels.
- `y_location` in 7: character top edge, screen pixels.
- `width` in 5: sprite width in pixels, 1–31.
- `height` in 5: sprite height in pixels, 1–31.
- `level_address` out 15: level memory read address.
- `tile_code` in 4: level memory read data.
- `left`, `right`, `up`, `down` out 1 each: blocked flags.
- `done` out 1: scan complete.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `done`=0, `level_address`=0. On `enable`=1, capture inputs and compute 8 probe pixels; go to ISSUE with probe index k=0.
- Probe pixels, with R=x+width, B=y+height:
  - left: (x-1, y) and (x-1, B-1).
  - right: (R, y) and (R, B-1).
  - up: (x, y-1) and (R-1, y-1).
  - down: (x, B) and (R-1, B).
- Tile coordinate = pixel >> TILE_SHIFT.
- Address arithmetic is 15-bit; the column is taken from x>>TILE_SHIFT, truncated only after the range check.
- A probe is out of range if any of the following holds; its address is issued as 0 and its result is forced solid:
  - x=0 (left probes);
  - y=0 (up probes);
  - tile column ≥ LEVEL_COLS;
  - tile row ≥ LEVEL_ROWS.
- ISSUE: one probe per cycle, k=0..7, from a registered `level_address`; after k=7, go to DRAIN.
- DRAIN: wait READ_LATENCY cycles for the last data, then go to DONE.
- Each returned `tile_code` is sampled exactly READ_LATENCY cycles after its address. Solid = `tile_code` ≠ 0. Per-direction result = OR of its two probes, accumulated in shadow bits.
- On entry to DONE: copy shadow bits to `left`/`right`/`up`/`down` in one edge; set `done`=1.
- DONE: hold `done`=1 and flags while `enable`=1. When `enable`=0, go to IDLE with `done`=0 on the next edge.
- Flags hold their last value between scans.
- `enable` dropping during ISSUE/DRAIN: abort to IDLE; flags unchanged; `done` stays 0.
- Inputs changing mid-scan are ignored (values captured at IDLE exit).
- Reset (`resetn`=0 at an edge, any state): go to IDLE; all outputs 0.

## Timing
- Edge E0: IDLE samples `enable`=1.
- Probe k address is visible in cycle E0+1+k.
- `done` rises at edge E0+9+READ_LATENCY: 10 cycles after E0 for latency 1, 11 for latency 2.
- `done` falls one edge after `enable` is sampled low.
- Minimum re-trigger: `enable` high again in the cycle after `done` falls.
- Reset values: `left`=`right`=`up`=`down`=`done`=0, `level_address`=0.

## Configuration
- `PLATFORM_TILE_EN` defined: tile code 4'hF is a one-way platform.
  - It counts as solid only for the two down probes.
  - It counts as empty for left, right and up.
- `PLATFORM_TILE_EN` undefined: every nonzero code, including 4'hF, is solid in all directions.

## Test plan
- Floor: tile 1 at address 20485 (row 10, col 5), x=40, y=72, w=h=8 -> `down`=1, other flags 0. `done` at E0+10 (READ_LATENCY=1).
- Left edge: x=0, y=40, all tiles 0 -> `left`=1, others 0. No memory data is required for the left probes.
- Bottom of level: y=112, h=8 (row 15 out of range) -> `down`=1.
- Handshake: hold `enable` 5 cycles after `done` -> `done` stays 1 and flags are stable. Drop `enable` -> `done`=0 next edge; re-enable -> new scan completes in 10 cycles.
- Abort and reset:
  - Drop `enable` at probe 3 -> flags unchanged, `done` never asserted.
  - Assert `resetn`=0 mid-DRAIN -> all outputs 0 next edge.
- Platform tile 4'hF at the right probe (row 9, col 6; x=40, y=72, w=8) and at the down probe:
  - With `PLATFORM_TILE_EN` -> `right`=0, `down`=1.
  - Without `PLATFORM_TILE_EN` -> `right`=1, `down`=1.
